// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM states, branch LUT contents, default widths.
package inst_fetch_pkg;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned CYC_W_DEF = 16;
  localparam int unsigned LUT_N     = 4;
  localparam int unsigned LUT_AW    = 16;
  localparam int unsigned REL_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Absolute jump targets, truncated to PC_W at the point of use
  localparam logic [LUT_AW-1:0] ABS_LUT [LUT_N] = '{16'd0, 16'd32, 16'd100, 16'd1000};

  // Relative branch offsets, two's complement
  localparam logic signed [REL_W-1:0] REL_LUT [LUT_N] = '{8'sd4, -8'sd4, 8'sd16, -8'sd16};

endpackage

// File: rtl/inst_fetch_branch_lut.sv
// Branch target lookup: absolute target and PC-relative target for the selected LUT entry.
module branch_lut
  import inst_fetch_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [1:0]      i_targ,
  input  logic [PC_W-1:0] i_pc,
  output logic [PC_W-1:0] o_abs_c,
  output logic [PC_W-1:0] o_rel_c
);

  logic signed [PC_W-1:0] w_off;

  // Sign-extend the 8-bit offset; the sum wraps modulo 2^PC_W
  assign w_off   = PC_W'(REL_LUT[i_targ]);
  assign o_abs_c = PC_W'(ABS_LUT[i_targ]);
  assign o_rel_c = i_pc + $unsigned(w_off);

endmodule

// File: rtl/inst_fetch.sv
// Program counter, Start/Done handshake FSM and RUN-cycle counter for the 9-bit core.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchAbs,
  input  logic             BranchRel,
  input  logic             Taken,
  input  logic [1:0]       PCTarg,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Done,
  output logic             Running,
  output logic [CYC_W-1:0] CycleCt
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CYC_W-1:0] r_cyc;
  logic             r_done;
  logic             r_running;
  logic [PC_W-1:0]  w_abs;
  logic [PC_W-1:0]  w_rel;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .i_targ  (PCTarg),
    .i_pc    (r_pc),
    .o_abs_c (w_abs),
    .o_rel_c (w_rel)
  );

  // FSM, PC and cycle counter; Done/Running registered alongside the state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cyc     <= '0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) r_state <= ARMED;
        end
        ARMED: begin
          r_pc  <= '0;
          r_cyc <= '0;
          if (!Start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (Start) begin
            // Abort: restart from address 0 once Start falls
            r_state   <= ARMED;
            r_pc      <= '0;
            r_cyc     <= '0;
            r_running <= 1'b0;
          end else begin
            if (r_cyc != '1) r_cyc <= r_cyc + CYC_W'(1);
            if (Ack) begin
              // Halt wins over any branch strobe; PC holds on the halt instruction
              r_state   <= HALT;
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end else if (BranchAbs) begin
              r_pc <= w_abs;
            end else if (BranchRel && Taken) begin
              r_pc <= w_rel;
            end else begin
              r_pc <= r_pc + PC_W'(1);
            end
          end
        end
        HALT: begin
          if (Start) begin
            r_state <= ARMED;
            r_done  <= 1'b0;
            r_pc    <= '0;
            r_cyc   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ProgCtr = r_pc;
  assign Done    = r_done;
  assign Running = r_running;
  assign CycleCt = r_cyc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus hand-written multi-cycle sequences.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        BranchAbs = 1'b0;
  logic        BranchRel = 1'b0;
  logic        Taken = 1'b0;
  logic [1:0]  PCTarg = 2'd0;
  logic        Ack = 1'b0;

  logic [9:0]  ProgCtr;
  logic        Done;
  logic        Running;
  logic [15:0] CycleCt;

  logic [9:0]  ProgCtr4;
  logic        Done4;
  logic        Running4;
  logic [3:0]  CycleCt4;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  inst_fetch #(.PC_W(10), .CYC_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchAbs(BranchAbs),
    .BranchRel(BranchRel), .Taken(Taken), .PCTarg(PCTarg), .Ack(Ack),
    .ProgCtr(ProgCtr), .Done(Done), .Running(Running), .CycleCt(CycleCt)
  );

  // Narrow cycle counter copy, driven identically, for saturation
  inst_fetch #(.PC_W(10), .CYC_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchAbs(BranchAbs),
    .BranchRel(BranchRel), .Taken(Taken), .PCTarg(PCTarg), .Ack(Ack),
    .ProgCtr(ProgCtr4), .Done(Done4), .Running(Running4), .CycleCt(CycleCt4)
  );

  typedef struct {
    string       nm;
    logic        rst, st, ba, br, tk;
    logic [1:0]  tg;
    logic        ack;
    logic [9:0]  pc;
    logic        dn, rn;
    logic [15:0] cc;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  function automatic vec_t mk(string nm, logic rst, logic st, logic ba, logic br, logic tk,
                              logic [1:0] tg, logic ack, logic [9:0] pc, logic dn, logic rn,
                              logic [15:0] cc);
    vec_t v;
    v.nm = nm; v.rst = rst; v.st = st; v.ba = ba; v.br = br; v.tk = tk;
    v.tg = tg; v.ack = ack; v.pc = pc; v.dn = dn; v.rn = rn; v.cc = cc;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic st, input logic ba, input logic br,
                       input logic tk, input logic [1:0] tg, input logic ack);
    Reset = rst; Start = st; BranchAbs = ba; BranchRel = br;
    Taken = tk; PCTarg = tg; Ack = ack;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] pc, input logic dn, input logic rn,
                     input logic [15:0] cc);
    total++;
    if (ProgCtr !== pc || Done !== dn || Running !== rn || CycleCt !== cc) begin
      bad++;
      $display("FAIL %s: got pc=%0d done=%0b run=%0b cyc=%0d, want pc=%0d done=%0b run=%0b cyc=%0d",
               nm, ProgCtr, Done, Running, CycleCt, pc, dn, rn, cc);
    end
  endtask

  task automatic chk4(input string nm, input logic [9:0] pc, input logic dn, input logic rn,
                      input logic [3:0] cc);
    total++;
    if (ProgCtr4 !== pc || Done4 !== dn || Running4 !== rn || CycleCt4 !== cc) begin
      bad++;
      $display("FAIL %s: got pc=%0d done=%0b run=%0b cyc=%0d, want pc=%0d done=%0b run=%0b cyc=%0d",
               nm, ProgCtr4, Done4, Running4, CycleCt4, pc, dn, rn, cc);
    end
  endtask

  initial begin
    logic [9:0]  e_pc;
    logic [15:0] e_cc;

    //            name          rst st ba br tk tg ack   pc  dn rn  cc
    vt[0]  = mk("reset0",       1, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0);
    vt[1]  = mk("reset1",       1, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0);
    vt[2]  = mk("armed0",       0, 1, 0, 0, 0, 0, 0,    0, 0, 0,  0);
    vt[3]  = mk("armed1",       0, 1, 1, 0, 0, 2, 0,    0, 0, 0,  0);
    vt[4]  = mk("armed2",       0, 1, 0, 0, 0, 0, 1,    0, 0, 0,  0);
    vt[5]  = mk("run_first",    0, 0, 0, 0, 0, 0, 0,    0, 0, 1,  0);
    vt[6]  = mk("seq1",         0, 0, 0, 0, 0, 0, 0,    1, 0, 1,  1);
    vt[7]  = mk("seq2",         0, 0, 0, 0, 0, 0, 0,    2, 0, 1,  2);
    vt[8]  = mk("seq3",         0, 0, 0, 0, 0, 0, 0,    3, 0, 1,  3);
    vt[9]  = mk("seq4",         0, 0, 0, 0, 0, 0, 0,    4, 0, 1,  4);
    vt[10] = mk("seq5",         0, 0, 0, 0, 0, 0, 0,    5, 0, 1,  5);
    vt[11] = mk("abs_100",      0, 0, 1, 0, 0, 2, 0,  100, 0, 1,  6);
    vt[12] = mk("after_abs",    0, 0, 0, 0, 0, 0, 0,  101, 0, 1,  7);
    vt[13] = mk("abs_32",       0, 0, 1, 0, 0, 1, 0,   32, 0, 1,  8);
    vt[14] = mk("rel_m16",      0, 0, 0, 1, 1, 3, 0,   16, 0, 1,  9);
    vt[15] = mk("rel_p4",       0, 0, 0, 1, 1, 0, 0,   20, 0, 1, 10);
    vt[16] = mk("rel_m4_taken", 0, 0, 0, 1, 1, 1, 0,   16, 0, 1, 11);
    vt[17] = mk("rel_p4_b",     0, 0, 0, 1, 1, 0, 0,   20, 0, 1, 12);
    vt[18] = mk("rel_not_tkn",  0, 0, 0, 1, 0, 1, 0,   21, 0, 1, 13);
    vt[19] = mk("taken_no_rel", 0, 0, 0, 0, 1, 2, 0,   22, 0, 1, 14);
    vt[20] = mk("abs_over_rel", 0, 0, 1, 1, 1, 0, 0,    0, 0, 1, 15);
    vt[21] = mk("abort_at0",    0, 1, 0, 0, 0, 0, 0,    0, 0, 0,  0);
    vt[22] = mk("rerun",        0, 0, 0, 0, 0, 0, 0,    0, 0, 1,  0);
    vt[23] = mk("r1",           0, 0, 0, 0, 0, 0, 0,    1, 0, 1,  1);
    vt[24] = mk("r2",           0, 0, 0, 0, 0, 0, 0,    2, 0, 1,  2);
    vt[25] = mk("r3",           0, 0, 0, 0, 0, 0, 0,    3, 0, 1,  3);
    vt[26] = mk("r4",           0, 0, 0, 0, 0, 0, 0,    4, 0, 1,  4);
    vt[27] = mk("r5",           0, 0, 0, 0, 0, 0, 0,    5, 0, 1,  5);
    vt[28] = mk("r6",           0, 0, 0, 0, 0, 0, 0,    6, 0, 1,  6);
    vt[29] = mk("r7",           0, 0, 0, 0, 0, 0, 0,    7, 0, 1,  7);
    vt[30] = mk("halt_prio",    0, 0, 1, 1, 1, 3, 1,    7, 1, 0,  8);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].st, vt[i].ba, vt[i].br, vt[i].tk, vt[i].tg, vt[i].ack);
      chk(vt[i].nm, vt[i].pc, vt[i].dn, vt[i].rn, vt[i].cc);
    end

    // HALT ignores all strobes
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      chk("halt_frozen", 10'd7, 1'b1, 1'b0, 16'd8);
    end

    // Restart from HALT
    drive(0, 1, 0, 0, 0, 0, 0); chk("restart_armed", 10'd0, 1'b0, 1'b0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0); chk("restart_run",   10'd0, 1'b0, 1'b1, 16'd0);

    // Count to PC=50 with saturation check on the narrow counter, then abort
    drive(0, 0, 1, 0, 0, 1, 0); chk("abs_32_b", 10'd32, 1'b0, 1'b1, 16'd1);
    e_pc = 10'd32; e_cc = 16'd1;
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      e_pc = e_pc + 10'd1; e_cc = e_cc + 16'd1;
      chk("count_to_50", e_pc, 1'b0, 1'b1, e_cc);
      chk4("sat4", e_pc, 1'b0, 1'b1, (e_cc > 16'd15) ? 4'd15 : 4'(e_cc));
    end
    drive(0, 1, 0, 0, 0, 0, 0); chk("abort_at50", 10'd0, 1'b0, 1'b0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0); chk("run_after_abort", 10'd0, 1'b0, 1'b1, 16'd0);

    // Reset mid-run at PC=300
    drive(0, 0, 1, 0, 0, 2, 0); chk("abs_100_b", 10'd100, 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 200; i++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("reach_300", 10'd300, 1'b0, 1'b1, 16'd201);
    drive(1, 0, 1, 0, 0, 3, 0); chk("reset_mid", 10'd0, 1'b0, 1'b0, 16'd0);
    chk4("reset_mid4", 10'd0, 1'b0, 1'b0, 4'd0);
    drive(0, 0, 1, 0, 0, 3, 0); chk("idle_ignores", 10'd0, 1'b0, 1'b0, 16'd0);

    // Relative wrap-around and sequential wrap at the top of the address space
    drive(0, 1, 0, 0, 0, 0, 0); chk("armed_w", 10'd0, 1'b0, 1'b0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0); chk("run_w",   10'd0, 1'b0, 1'b1, 16'd0);
    drive(0, 0, 1, 0, 0, 3, 0); chk("abs_1000", 10'd1000, 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("reach_1020", 10'd1020, 1'b0, 1'b1, 16'd21);
    drive(0, 0, 0, 1, 1, 2, 0); chk("rel_wrap", 10'd12, 1'b0, 1'b1, 16'd22);
    drive(0, 0, 1, 0, 0, 3, 0); chk("abs_1000_b", 10'd1000, 1'b0, 1'b1, 16'd23);
    for (int i = 0; i < 23; i++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("reach_1023", 10'd1023, 1'b0, 1'b1, 16'd46);
    drive(0, 0, 0, 0, 0, 0, 0); chk("seq_wrap", 10'd0, 1'b0, 1'b1, 16'd47);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
